// File: rtl/dsdemod3.sv
// Third-order CIC decimator for a single-bit delta-sigma stream.
// Three integrators run every clock; three combs run once every 2^lr clocks.
module dsdemod3 #(
    parameter int n  = 16,
    parameter int lr = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                in,
    output logic signed [n-1:0] out,
    output logic                out_valid
);

    localparam int w  = 3*lr + 2;
    localparam int sh = 3*lr - (n-1);

    logic signed [w-1:0] i1, i2, i3;
    logic signed [w-1:0] d1, d2, d3;
    logic signed [w-1:0] x, c1, c2, c3;
    logic signed [n:0]   scaled;
    logic signed [n-1:0] sat;
    logic [lr-1:0]       cnt;
    logic [1:0]          warm;
    logic                dec;

    assign x   = in ? {{(w-1){1'b0}}, 1'b1} : {w{1'b1}};
    assign dec = (cnt == {lr{1'b1}});

    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // Dropping the low sh bits is the arithmetic shift; the result is exactly n+1 bits wide.
    assign scaled = c3[w-1:sh];
    assign sat    = (scaled[n] ^ scaled[n-1])
                    ? (scaled[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}})
                    : scaled[n-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            cnt       <= '0;
            warm      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            i1  <= i1 + x;
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            cnt <= cnt + 1'b1;
            if (dec) begin
                d1        <= i3;
                d2        <= c1;
                d3        <= c2;
                out       <= sat;
                out_valid <= (warm == 2'd3);
                if (warm != 2'd3)
                    warm <= warm + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsdemod3.sv
// Directed and random checks for dsdemod3 at n=16, lr=6.
module tb_dsdemod3;

    localparam int R = 64;

    logic                clk = 1'b0;
    logic                clr = 1'b0;
    logic                in  = 1'b0;
    logic signed [15:0]  out;
    logic                out_valid;

    int vectors = 0;
    int errors  = 0;

    dsdemod3 #(.n(16), .lr(6)) dut (
        .clk       (clk),
        .clr       (clr),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    pat;
        int    exp_out;
        string name;
    } vec_t;

    vec_t tbl[4];

    logic signed [19:0] m1, m2, m3, md1, md2, md3;
    int                 mcnt, mwarm, mout;
    logic               mvalid;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b);
        in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clr = 1'b0;
        in  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_out", int'(out), 0);
        chk("reset_valid", int'(out_valid), 0);
        clr = 1'b1;
        #1;
        chk("release_valid", int'(out_valid), 0);
    endtask

    function automatic logic pbit(input int pat, input int k);
        case (pat)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (k % 2) == 1;
            default: return (k % 4) != 0;
        endcase
    endfunction

    task automatic model_reset;
        m1 = '0; m2 = '0; m3 = '0;
        md1 = '0; md2 = '0; md3 = '0;
        mcnt = 0; mwarm = 0; mout = 0; mvalid = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic signed [19:0] xv, c1, c2, c3;
        int v;
        xv = b ? 20'sd1 : -20'sd1;
        c1 = m3 - md1;
        c2 = c1 - md2;
        c3 = c2 - md3;
        if (mcnt == R-1) begin
            md1 = m3;
            md2 = c1;
            md3 = c2;
            v = int'(c3) >>> 3;
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            mout   = v;
            mvalid = (mwarm == 3);
            if (mwarm < 3) mwarm++;
        end else begin
            mvalid = 1'b0;
        end
        m3 = m3 + m2;
        m2 = m2 + m1;
        m1 = m1 + xv;
        mcnt = (mcnt + 1) % R;
    endtask

    // Strobe expected only after decimation edges 4, 5, ... counted from release.
    task automatic run_pattern(input int pat, input int nsteps, input int exp_out, input string name);
        logic ev;
        for (int k = 1; k <= nsteps; k++) begin
            step(pbit(pat, k));
            ev = (k >= 4*R) && (k % R == 0);
            chk({name, "_strobe"}, int'(out_valid), int'(ev));
            if (ev)
                chk({name, "_out"}, int'(out), exp_out);
        end
    endtask

    initial begin
        tbl[0] = '{pat: 0, exp_out: 32767,  name: "ones"};
        tbl[1] = '{pat: 1, exp_out: -32768, name: "zeros"};
        tbl[2] = '{pat: 2, exp_out: 0,      name: "alt"};
        tbl[3] = '{pat: 3, exp_out: 16384,  name: "three_one"};

        for (int t = 0; t < 4; t++) begin
            do_reset();
            run_pattern(tbl[t].pat, 7*R, tbl[t].exp_out, tbl[t].name);
        end

        // Reset pulse mid-frame after warm-up: everything restarts.
        do_reset();
        run_pattern(0, 6*R + 40, 32767, "pre_clr");
        clr = 1'b0;
        #1;
        chk("clr_out", int'(out), 0);
        chk("clr_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("clr_hold_valid", int'(out_valid), 0);
        chk("clr_hold_out", int'(out), 0);
        clr = 1'b1;
        #1;
        chk("clr_release_valid", int'(out_valid), 0);
        run_pattern(0, 5*R, 32767, "post_clr");

        // Random bits with drifting density against the reference model.
        do_reset();
        model_reset();
        for (int k = 1; k <= 40000; k++) begin
            logic b;
            int dens;
            dens = ((k / 4096) * 37) % 101;
            b = ($urandom_range(0, 99) < dens);
            step(b);
            model_edge(b);
            if (out_valid !== mvalid || (mvalid && int'(out) != mout)) begin
                chk("rand_valid", int'(out_valid), int'(mvalid));
                if (mvalid) chk("rand_out", int'(out), mout);
            end else begin
                vectors++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
